// File: rtl/fft_chk_pkg.sv
// Shared types and constants for the FFT output stream checker.
// Lane field helpers keep the top and the testbench agreeing on beat packing.
package fft_chk_pkg;

  typedef enum logic [1:0] {IDLE, PREFETCH, CHECK, DONE} chkState_t;

  localparam int ERRW = 16;
  localparam logic [ERRW-1:0] ERR_MAX = '1;

  // Lane k occupies [2*nbits*(k+1)-1 : 2*nbits*k], real part in the upper half.
  function automatic int laneLo(input int lane, input int nbits);
    return 2 * nbits * lane;
  endfunction

  function automatic int laneWidth(input int nbits);
    return 2 * nbits;
  endfunction

endpackage

// File: rtl/fft_lane_cmp.sv
// Single complex-lane tolerance compare: both components must be within TOL.
module fft_lane_cmp #(
  parameter int NBITS_out = 10,
  parameter int TOL       = 0
) (
  input  logic [2*NBITS_out-1:0] a,
  input  logic [2*NBITS_out-1:0] b,
  output logic                   match
);

  localparam int W = NBITS_out + 1;
  localparam logic [W-1:0] TOLV = W'(TOL);

  logic signed [W-1:0] dRe, dIm;
  logic [W-1:0] mRe, mIm;

  // One extra bit of headroom makes the difference exact for any operand pair.
  always_comb begin
    dRe = $signed({a[2*NBITS_out-1], a[2*NBITS_out-1:NBITS_out]})
        - $signed({b[2*NBITS_out-1], b[2*NBITS_out-1:NBITS_out]});
    dIm = $signed({a[NBITS_out-1], a[NBITS_out-1:0]})
        - $signed({b[NBITS_out-1], b[NBITS_out-1:0]});
    mRe = dRe[W-1] ? -dRe : dRe;
    mIm = dIm[W-1] ? -dIm : dIm;
    match = (mRe <= TOLV) && (mIm <= TOLV);
  end

endmodule

// File: rtl/fft_stream_checker.sv
// Compares an NLANES-wide FFT output stream with a golden ROM over NFRAMES
// frames, counting mismatching beats and capturing the first failure.
module fft_stream_checker
  import fft_chk_pkg::*;
#(
  parameter int NBITS_out = 10,
  parameter int NLANES    = 4,
  parameter int N         = 128,
  parameter int NFRAMES   = 1,
  parameter int TOL       = 0,
  parameter int ADDRW     = $clog2(N / NLANES)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          dut_valid,
  input  logic [NLANES*2*NBITS_out-1:0] dut_data,
  output logic [ADDRW-1:0]              ref_addr,
  input  logic [NLANES*2*NBITS_out-1:0] ref_data,
  output logic                          busy,
  output logic [NLANES-1:0]             lane_match,
  output logic [ERRW-1:0]               err_count,
  output logic [15:0]                   first_err_frame,
  output logic [ADDRW-1:0]              first_err_addr,
  output logic [NLANES-1:0]             first_err_lanes,
  output logic                          done,
  output logic                          pass
);

  localparam int DEPTH = N / NLANES;
  localparam logic [ADDRW-1:0] LAST_PTR = ADDRW'(DEPTH - 1);
  localparam logic [15:0] LAST_FRAME = 16'(NFRAMES - 1);

  chkState_t state;
  logic [ADDRW-1:0] ptr, nextPtr;
  logic [15:0] frame;
  logic [NLANES-1:0] laneOk;
  logic accept, lastPtr, lastBeat, beatBad;

  for (genvar k = 0; k < NLANES; k++) begin : gLane
    localparam int LO = laneLo(k, NBITS_out);
    localparam int LW = laneWidth(NBITS_out);
    fft_lane_cmp #(.NBITS_out(NBITS_out), .TOL(TOL)) uCmp (
      .a(dut_data[LO +: LW]),
      .b(ref_data[LO +: LW]),
      .match(laneOk[k])
    );
  end

  assign accept   = (state == CHECK) && dut_valid;
  assign lastPtr  = (ptr == LAST_PTR);
  assign nextPtr  = lastPtr ? '0 : ptr + 1'b1;
  assign lastBeat = accept && lastPtr && (frame == LAST_FRAME);
  assign beatBad  = ~&laneOk;

  // Look one word ahead on an accept so the ROM's registered output lines up
  // with the next beat; otherwise hold the current word.
  assign ref_addr = accept ? nextPtr : ptr;
  assign busy     = (state == PREFETCH) || (state == CHECK);
  assign pass     = done && (err_count == '0);

  // err_count only leaves zero through a mismatch and saturates rather than
  // wrapping, so zero means no failure has been captured yet this run.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      ptr             <= '0;
      frame           <= '0;
      lane_match      <= '1;
      err_count       <= '0;
      first_err_frame <= '0;
      first_err_addr  <= '0;
      first_err_lanes <= '0;
      done            <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state           <= PREFETCH;
            ptr             <= '0;
            frame           <= '0;
            lane_match      <= '1;
            err_count       <= '0;
            first_err_frame <= '0;
            first_err_addr  <= '0;
            first_err_lanes <= '0;
            done            <= 1'b0;
          end
        end
        PREFETCH: state <= CHECK;
        CHECK: begin
          if (dut_valid) begin
            ptr        <= nextPtr;
            lane_match <= laneOk;
            if (lastPtr) frame <= frame + 16'd1;
            if (beatBad) begin
              if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
              if (err_count == '0) begin
                first_err_frame <= frame;
                first_err_addr  <= ptr;
                first_err_lanes <= ~laneOk;
              end
            end
            if (lastBeat) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
